// File: rtl/sprite_compositor.sv
// Purpose: merges overlay, N keyed player sprites and a procedural stage background into one 12-bit RGB pixel stream.
// Latency: ROM_LATENCY+2 cycles from scan position / bright / overlay inputs to rgb; spr_addr is registered one cycle after the scan.
// Backpressure: none, one pixel per clock with no stalls; the caller delays sync by the same latency.
//
// Ports:
//   clk, rst              pixel clock, synchronous active-high reset
//   bright, hCount/vCount scan position and visible-area flag from the VGA timing generator
//   spr_x/spr_y           per-sprite top-left corner, 10 bits each, sprite i at [10i+9:10i]
//   flip, flash_trig      per-sprite horizontal mirror and hit-flash start pulse
//   spr_addr / spr_pixel  external sprite ROM address (registered) and returned data
//   ovl_valid/ovl_pixel   overlay layer (health/shield bars), highest priority when bright
//   rgb                   registered {R,G,B} output
module sprite_compositor #(
   parameter int NUM_SPRITES  = 2,
   parameter int SW_LOG2      = 7,
   parameter int SH_LOG2      = 7,
   parameter int ROM_LATENCY  = 1,
   parameter int GROUND_Y     = 394,
   parameter int KEY_B_MIN    = 12,
   parameter int FLASH_FRAMES = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   bright,
   input  logic [9:0]                             hCount,
   input  logic [9:0]                             vCount,
   input  logic [10*NUM_SPRITES-1:0]              spr_x,
   input  logic [10*NUM_SPRITES-1:0]              spr_y,
   input  logic [NUM_SPRITES-1:0]                 flip,
   input  logic [NUM_SPRITES-1:0]                 flash_trig,
   output logic [(SW_LOG2+SH_LOG2)*NUM_SPRITES-1:0] spr_addr,
   input  logic [12*NUM_SPRITES-1:0]              spr_pixel,
   input  logic                                   ovl_valid,
   input  logic [11:0]                            ovl_pixel,
   output logic [11:0]                            rgb
);

   localparam int          AW    = SW_LOG2 + SH_LOG2;
   localparam int          FW    = $clog2(FLASH_FRAMES + 1);
   localparam logic [10:0] SPR_W = 11'(1 << SW_LOG2);
   localparam logic [10:0] SPR_H = 11'(1 << SH_LOG2);

   // Side-band data that travels alongside the ROM read. Only bit 4 of the
   // column is needed by the ground checkerboard, so only that bit is carried.
   typedef struct packed {
      logic                   bright;
      logic                   h4;
      logic [9:0]             v;
      logic [NUM_SPRITES-1:0] in_reg;
      logic                   ovl_valid;
      logic [11:0]            ovl_pixel;
   } sb_t;

   logic [NUM_SPRITES-1:0] in_reg;
   logic [AW*NUM_SPRITES-1:0] addr_d;
   sb_t                    sb_in;
   sb_t                    sb_q [0:ROM_LATENCY];
   sb_t                    sb_o;
   logic                   frame_tick;
   logic [NUM_SPRITES-1:0][FW-1:0] fcnt;
   logic                   spr_hit;
   logic [11:0]            spr_col;
   logic [3:0]             sky_b;
   logic [3:0]             ground_g;
   logic [11:0]            rgb_d;

   function automatic logic is_opaque(input logic [11:0] p);
      return !((p[11:4] == 8'h00) && (32'(p[3:0]) >= KEY_B_MIN));
   endfunction

   // Stage 0: region test and ROM address per sprite. Comparisons are 11 bits
   // wide so a sprite placed near 1023 cannot wrap back onto column/row 0.
   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
      logic [10:0]        x11;
      logic [10:0]        y11;
      logic [SW_LOG2-1:0] lx_raw;
      logic [SW_LOG2-1:0] lx;
      logic [SH_LOG2-1:0] ly;

      assign x11 = {1'b0, spr_x[10*i +: 10]};
      assign y11 = {1'b0, spr_y[10*i +: 10]};
      assign in_reg[i] = ({1'b0, hCount} >= x11) && ({1'b0, hCount} < x11 + SPR_W) &&
                         ({1'b0, vCount} >= y11) && ({1'b0, vCount} < y11 + SPR_H);
      // Low bits of the difference only depend on low bits of the operands.
      assign lx_raw = hCount[SW_LOG2-1:0] - spr_x[10*i +: SW_LOG2];
      assign ly     = vCount[SH_LOG2-1:0] - spr_y[10*i +: SH_LOG2];
      // W-1-lx equals the bitwise complement because W is a power of two.
      assign lx     = flip[i] ? ~lx_raw : lx_raw;
      assign addr_d[AW*i +: AW] = in_reg[i] ? {ly, lx} : '0;
   end

   assign sb_in = '{bright:    bright,
                    h4:        hCount[4],
                    v:         vCount,
                    in_reg:    in_reg,
                    ovl_valid: ovl_valid,
                    ovl_pixel: ovl_pixel};

   // Address register plus side-band delay line; stage ROM_LATENCY lines up
   // with the ROM word returned for the address registered alongside stage 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         spr_addr <= '0;
         for (int k = 0; k <= ROM_LATENCY; k++) begin
            sb_q[k] <= '0;
         end
      end else begin
         spr_addr <= addr_d;
         sb_q[0]  <= sb_in;
         for (int k = 1; k <= ROM_LATENCY; k++) begin
            sb_q[k] <= sb_q[k-1];
         end
      end
   end

   assign sb_o = sb_q[ROM_LATENCY];

   // Hit flash: counts frames down from FLASH_FRAMES; a trigger beats the tick.
   assign frame_tick = (hCount == 10'd0) && (vCount == 10'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         fcnt <= '0;
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (flash_trig[i]) begin
               fcnt[i] <= FW'(FLASH_FRAMES);
            end else if (frame_tick && (fcnt[i] != '0)) begin
               fcnt[i] <= fcnt[i] - FW'(1);
            end
         end
      end
   end

   // Sprite layer: walk from lowest priority upward so index 0 ends up on top.
   always_comb begin
      spr_hit = 1'b0;
      spr_col = 12'h000;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (sb_o.in_reg[i] && is_opaque(spr_pixel[12*i +: 12])) begin
            spr_hit = 1'b1;
            spr_col = fcnt[i][0] ? 12'hFFF : spr_pixel[12*i +: 12];
         end
      end
   end

   assign sky_b    = (sb_o.v[9:8] != 2'b00) ? 4'hF : sb_o.v[7:4];
   assign ground_g = (sb_o.h4 ^ sb_o.v[3]) ? 4'hC : 4'h8;

   always_comb begin
      rgb_d = 12'h000;
      if (!sb_o.bright) begin
         rgb_d = 12'h000;
      end else if (sb_o.ovl_valid) begin
         rgb_d = sb_o.ovl_pixel;
      end else if (spr_hit) begin
         rgb_d = spr_col;
      end else if (32'(sb_o.v) < GROUND_Y) begin
         rgb_d = {8'h00, sky_b};
      end else begin
         rgb_d = {4'h0, ground_g, 4'h1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb <= 12'h000;
      end else begin
         rgb <= rgb_d;
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed self-checking bench for sprite_compositor with default parameters.
// A one-cycle registered ROM model stands in for the external sprite ROMs:
// it returns either the low 12 address bits or a fixed per-sprite colour.
module tb_sprite_compositor;

   logic        clk = 1'b0;
   logic        rst;
   logic        bright;
   logic [9:0]  hCount, vCount;
   logic [19:0] spr_x, spr_y;
   logic [1:0]  flip, flash_trig;
   logic [27:0] spr_addr;
   logic [23:0] spr_pixel = '0;
   logic        ovl_valid;
   logic [11:0] ovl_pixel;
   logic [11:0] rgb;

   logic        rom_mode;
   logic [11:0] pix0, pix1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sprite_compositor dut (
      .clk(clk), .rst(rst), .bright(bright), .hCount(hCount), .vCount(vCount),
      .spr_x(spr_x), .spr_y(spr_y), .flip(flip), .flash_trig(flash_trig),
      .spr_addr(spr_addr), .spr_pixel(spr_pixel),
      .ovl_valid(ovl_valid), .ovl_pixel(ovl_pixel), .rgb(rgb)
   );

   always @(posedge clk) begin
      spr_pixel[11:0]  <= rom_mode ? pix0 : spr_addr[11:0];
      spr_pixel[23:12] <= rom_mode ? pix1 : spr_addr[25:14];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic scan(input logic [9:0] h, input logic [9:0] v);
      hCount = h;
      vCount = v;
   endtask

   // Hold a scan position for the full pipeline depth, then check rgb.
   task automatic scan_check(input string tag, input logic [9:0] h, input logic [9:0] v,
                             input logic [11:0] exp);
      scan(h, v);
      repeat (3) step();
      check(tag, 32'(rgb), 32'(exp));
   endtask

   task automatic tick(input logic trig);
      scan(10'd0, 10'd0);
      flash_trig = {1'b0, trig};
      step();
      flash_trig = 2'b00;
   endtask

   // Tick n frames from a known count, checking the flash phase each frame.
   task automatic run_frames(input string tag, input int start_cnt, input int n);
      int cnt;
      for (int k = 1; k <= n; k++) begin
         tick(1'b0);
         cnt = (start_cnt - k < 0) ? 0 : start_cnt - k;
         scan_check($sformatf("%s_f%0d", tag, k), 10'd310, 10'd310,
                    cnt[0] ? 12'hFFF : 12'hF00);
      end
   endtask

   initial begin
      rst = 1'b1; bright = 1'b1; flip = 2'b00; flash_trig = 2'b00;
      ovl_valid = 1'b0; ovl_pixel = 12'h000;
      rom_mode = 1'b0; pix0 = 12'h000; pix1 = 12'h000;
      spr_x = {10'd1000, 10'd100};
      spr_y = {10'd1000, 10'd200};
      scan(10'd500, 10'd100);

      // Reset held for 5 cycles with bright=1.
      for (int k = 0; k < 5; k++) begin
         step();
         check($sformatf("rst_rgb%0d", k), 32'(rgb), 32'h000);
         check($sformatf("rst_addr%0d", k), 32'(spr_addr), 32'h0);
      end
      rst = 1'b0;
      check("post_rst0", 32'(rgb), 32'h000);
      step();
      check("post_rst1", 32'(rgb), 32'h000);
      step();
      check("post_rst2", 32'(rgb), 32'h000);
      step();
      check("post_rst_sky", 32'(rgb), 32'h006);

      // Addressing and exact latency: one pixel in sprite 0, then sky.
      scan(10'd103, 10'd205);
      step();
      check("addr0", 32'(spr_addr[13:0]), 32'h0283);
      scan(10'd500, 10'd100);
      step();
      check("addr0_out", 32'(spr_addr[13:0]), 32'h0);
      step();
      check("rgb_rom", 32'(rgb), 32'h283);
      step();
      check("rgb_next_sky", 32'(rgb), 32'h006);

      // Horizontal flip.
      flip = 2'b01;
      scan(10'd103, 10'd205);
      step();
      check("addr0_flip", 32'(spr_addr[13:0]), 32'(14'h2FC));
      step(); step();
      check("rgb_flip", 32'(rgb), 32'h2FC);
      flip = 2'b00;

      // Region edges and 11-bit no-wrap behaviour.
      scan(10'd227, 10'd205);
      step();
      check("addr0_right_edge", 32'(spr_addr[13:0]), 32'h2FF);
      scan(10'd228, 10'd205);
      step();
      check("addr0_past_right", 32'(spr_addr[13:0]), 32'h0);
      scan(10'd99, 10'd205);
      step();
      check("addr0_before_left", 32'(spr_addr[13:0]), 32'h0);
      scan(10'd1010, 10'd1010);
      step();
      check("addr1_high", 32'(spr_addr[27:14]), 32'h50A);
      scan(10'd5, 10'd5);
      step();
      check("addr1_nowrap", 32'(spr_addr[27:14]), 32'h0);

      // Overlap, transparency key and overlay priority.
      spr_x = {10'd300, 10'd300};
      spr_y = {10'd300, 10'd300};
      rom_mode = 1'b1; pix0 = 12'h00D; pix1 = 12'h0F0;
      scan_check("overlap_key", 10'd310, 10'd310, 12'h0F0);
      pix0 = 12'hF00;
      scan_check("overlap_spr0", 10'd310, 10'd310, 12'hF00);
      ovl_valid = 1'b1; ovl_pixel = 12'h0A0;
      scan_check("overlay", 10'd310, 10'd310, 12'h0A0);
      ovl_valid = 1'b0;

      // Background and blanking.
      scan_check("sky_v100", 10'd500, 10'd100, 12'h006);
      scan_check("sky_v300", 10'd500, 10'd300, 12'h00F);
      scan_check("ground_h16", 10'd16, 10'd400, 12'h0C1);
      scan_check("ground_h0", 10'd0, 10'd400, 12'h081);
      bright = 1'b0;
      scan_check("blank", 10'd16, 10'd400, 12'h000);
      bright = 1'b1;

      // Hit flash: trigger on a frame tick, run out the full count.
      tick(1'b1);
      scan_check("flash_f0", 10'd310, 10'd310, 12'hF00);
      run_frames("flash", 8, 9);

      // Retrigger on the tick of frame 4: the load wins and restarts from 8.
      tick(1'b1);
      run_frames("pre_retrig", 8, 3);
      tick(1'b1);
      scan_check("retrig_f0", 10'd310, 10'd310, 12'hF00);
      run_frames("retrig", 8, 9);

      // Reset in mid-flash aborts it.
      tick(1'b1);
      tick(1'b0);
      scan_check("midflash", 10'd310, 10'd310, 12'hFFF);
      rst = 1'b1;
      step();
      rst = 1'b0;
      scan_check("flash_abort", 10'd310, 10'd310, 12'hF00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised, pipelined pixel compositor for the street-fighter VGA path. It takes the scan position, generates ROM addresses for N player sprites, and drops keyed background-colour pixels. It merges an overlay layer (health/shield bars), the sprites and a procedural stage background into one registered 12-bit RGB stream. It sits between the VGA timing generator and the DAC pins, with sprite ROMs kept outside so each player can use a different ROM or action bank, and it adds per-sprite horizontal flip and a frame-counted hit-flash effect.

## Interface
- NUM_SPRITES, 2, number of sprite layers; index 0 has the highest priority.
- SW_LOG2, 7, log2 sprite width (128 px).
- SH_LOG2, 7, log2 sprite height (128 px).
- ROM_LATENCY, 1, cycles from `spr_addr` to matching `spr_pixel` (range 1..3).
- GROUND_Y, 394, first scanline drawn as ground.
- KEY_B_MIN, 12, a sprite pixel with R=0, G=0, B>=KEY_B_MIN is transparent.
- FLASH_FRAMES, 8, frame count of the hit flash.
- clk  in  1  pixel clock, the only clock.
- rst  in  1  reset, synchronous, active-high.
- bright  in  1  visible-area flag.
- hCount, vCount  in  10 each  scan position.
- spr_x, spr_y  in  10*NUM_SPRITES each  top-left of sprite i at bits [10i+9:10i].
- flip  in  NUM_SPRITES  1 = draw sprite i mirrored horizontally.
- flash_trig  in  NUM_SPRITES  1-cycle pulse that starts the hit flash for sprite i.
- spr_addr  out  (SW_LOG2+SH_LOG2)*NUM_SPRITES  registered ROM address per sprite.
- spr_pixel  in  12*NUM_SPRITES  ROM data, valid ROM_LATENCY cycles after its address.
- ovl_valid  in  1  overlay pixel present at this hCount/vCount.
- ovl_pixel  in  12  overlay colour.
- rgb  out  12  registered output colour {R,G,B}.

## Operation
- Stage 0, combinational on the inputs:
  - In-region test per sprite: hCount >= x, hCount < x+W, vCount >= y, vCount < y+H.
  - All sums are computed in 11 bits, so a sprite near 1023 does not wrap back into the region.
  - Local coordinates: lx = hCount-x and ly = vCount-y, each truncated to SW_LOG2/SH_LOG2 bits.
  - If flip[i] is set, lx becomes W-1-lx.
  - Address is {ly,lx}. When the sprite is out of region the address is 0.
  - The address is registered into spr_addr at the clock edge.
- Side-band delay line: bright, hCount, vCount, per-sprite region flags, ovl_valid and ovl_pixel are delayed by ROM_LATENCY+1 cycles to line up with spr_pixel.
- Compose stage, registered into rgb. The first matching rule wins:
  1. Delayed bright=0 gives 12'h000.
  2. ovl_valid gives ovl_pixel.
  3. Lowest index i that is in region and opaque gives spr_pixel[i], or 12'hFFF when flash is active for i.
  4. vCount < GROUND_Y gives sky: R=0, G=0, B = vCount[9:8]!=0 ? 4'hF : vCount[7:4].
  5. Otherwise ground: R=0, G = 8 + (hCount[4]^vCount[3] ? 4 : 0), B=1.
- Hit flash:
  - Per-sprite counter fcnt[i], wide enough to hold FLASH_FRAMES.
  - frame_tick is high for one cycle when the undelayed hCount==0 and vCount==0.
  - flash_trig[i] loads fcnt=FLASH_FRAMES. On frame_tick with fcnt!=0, fcnt decrements.
  - If flash_trig and frame_tick occur in the same cycle, the load wins.
  - A retrigger while the flash is active reloads the counter.
  - Flash is active when fcnt[0]=1, so the sprite alternates white and normal every frame. At fcnt=0 the sprite is drawn normally.
  - The flash affects opaque pixels only; transparent pixels still fall through.
- Overlapping sprites: sprite 0 always beats sprite 1. Transparent pixels of sprite 0 reveal sprite 1.

## Timing
- Latency from hCount/vCount/bright/ovl_* to rgb is L = ROM_LATENCY+2 cycles (L=3 by default). The sync path must be delayed by L to match.
- spr_addr changes 1 cycle after hCount.
- A sprite, flip or position change takes effect on the next pixel. Sprite positions should be updated only during blanking to avoid tearing; no internal latching is done.
- Reset, on the first clk edge with rst=1:
  - rgb=0, all spr_addr=0, all fcnt=0, and every delay-line stage including delayed bright is cleared.
  - rgb stays 12'h000 for L cycles after rst is released.
- Reset in mid-frame or mid-flash aborts the flash immediately.
- Throughput is one pixel per clock with no stalls.

## Test plan
- Reset held for 5 cycles with bright=1 → rgb=000 during reset and for 3 cycles after release; spr_addr=0.
- Sprite 0 at (100,200), sprite 1 far away, ROM model returning {addr[11:0]}, scan h=103, v=205 → spr_addr0=14'h0283 one cycle later; rgb equals the ROM word 3 cycles after the scan.
- Same scan with flip[0]=1 → spr_addr0 = {7'd5, 7'd124}.
- Both sprites at (300,300), sprite 0 pixel 00D and sprite 1 pixel 0F0 → rgb=0F0. Change sprite 0 pixel to F00 → rgb=F00. Set ovl_valid with ovl_pixel=0A0 → rgb=0A0.
- Empty scene at v=100 → B=6. At v=400, h=16 → rgb=0C1; at h=0 → rgb=081. With bright=0 → 000.
- Pulse flash_trig[0] on the same cycle as frame_tick → fcnt=8. Over the next 8 frames the opaque pixel alternates normal/FFF on frames 7,5,3,1 and is normal from frame 8 on. A retrigger at frame 4 restarts the count from 8.
